// File: rtl/xor_stream_decrypt_if.sv
// Byte stream, key and status signals between the decryptor and its
// ciphertext source / plaintext sink.
interface xor_stream_decrypt_if;
  logic        key_load;
  logic [7:0]  key_in;
  logic        ct_valid;
  logic [7:0]  ct_data;
  logic        ct_ready;
  logic        pt_valid;
  logic [7:0]  pt_data;
  logic        pt_ready;
  logic        key_err;
  logic [15:0] byte_count;

  modport master (
    output key_load, key_in, ct_valid, ct_data, pt_ready,
    input  ct_ready, pt_valid, pt_data, key_err, byte_count
  );

  modport slave (
    input  key_load, key_in, ct_valid, ct_data, pt_ready,
    output ct_ready, pt_valid, pt_data, key_err, byte_count
  );
endinterface

// File: rtl/xor_stream_decrypt.sv
// Stream decryptor: XORs each accepted ciphertext byte with a key-seeded
// 8-bit Galois LFSR keystream and holds the result in an output register.
module xor_stream_decrypt #(
  parameter logic [7:0] KEY_DEFAULT = 8'h55,
  parameter logic [7:0] TAPS        = 8'hB8
) (
  input logic              CLOCK_50,
  input logic              RESET,
  xor_stream_decrypt_if.slave bus
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_RESEED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  ks_q, ks_d;
  logic        pt_valid_q, pt_valid_d;
  logic [7:0]  pt_data_q, pt_data_d;
  logic        key_err_q, key_err_d;
  logic [15:0] byte_count_q, byte_count_d;

  logic       ct_ready;
  logic       accept;
  logic [7:0] ks_step;
  logic [7:0] seed;

  // Ready looks straight through to pt_ready so a draining sink keeps full rate.
  assign ct_ready = (state_q == ST_RUN) && !bus.key_load && (!pt_valid_q || bus.pt_ready);
  assign accept   = bus.ct_valid && ct_ready;
  assign ks_step  = ks_q[0] ? ((ks_q >> 1) ^ TAPS) : (ks_q >> 1);
  // A zero seed would lock the LFSR at zero, so fall back to the default key.
  assign seed     = (bus.key_in == 8'd0) ? KEY_DEFAULT : bus.key_in;

  always_comb begin
    state_d      = ST_RUN;
    ks_d         = ks_q;
    pt_valid_d   = pt_valid_q;
    pt_data_d    = pt_data_q;
    key_err_d    = key_err_q;
    byte_count_d = byte_count_q;

    if (bus.key_load) begin
      state_d      = ST_RESEED;
      ks_d         = seed;
      key_err_d    = (bus.key_in == 8'd0);
      byte_count_d = 16'd0;
      pt_valid_d   = 1'b0;
    end else if (accept) begin
      pt_data_d  = bus.ct_data ^ ks_q;
      pt_valid_d = 1'b1;
      ks_d       = ks_step;
      if (byte_count_q != 16'hFFFF) begin
        byte_count_d = byte_count_q + 16'd1;
      end
    end else if (bus.pt_ready) begin
      pt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_RUN;
      ks_q         <= KEY_DEFAULT;
      pt_valid_q   <= 1'b0;
      pt_data_q    <= 8'd0;
      key_err_q    <= 1'b0;
      byte_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      ks_q         <= ks_d;
      pt_valid_q   <= pt_valid_d;
      pt_data_q    <= pt_data_d;
      key_err_q    <= key_err_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign bus.ct_ready   = ct_ready;
  assign bus.pt_valid   = pt_valid_q;
  assign bus.pt_data    = pt_data_q;
  assign bus.key_err    = key_err_q;
  assign bus.byte_count = byte_count_q;

endmodule
